// File: rtl/jtframe_frame_mon_pkg.sv
// Shared types for the frame monitor and its harness consumers.
// Holds the dump FSM encoding and the frame-count width.
package jtframe_frame_mon_pkg;

  localparam int FCW = 32;

  typedef enum logic [1:0] {
    WAIT_DL = 2'd0,
    ARMED   = 2'd1,
    DUMPING = 2'd2,
    DONE    = 2'd3
  } fsm_t;

endpackage

// File: rtl/jtframe_vs_period.sv
// Vertical sync falling-edge detector and frame-period meter.
// Falls are masked while a ROM download is in progress.
module jtframe_vs_period #(
  parameter int PW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vs,
  input  logic          downloading,
  output logic          fall,
  output logic          vs_fall,
  output logic [PW-1:0] period,
  output logic          period_ok
);

  logic          vs_l;
  logic          seen;
  logic [PW-1:0] cnt;
  logic          sat;

  assign sat  = &cnt;
  assign fall = vs_l & ~vs & ~downloading;

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_l      <= 1'b1;
      vs_fall   <= 1'b0;
      cnt       <= '0;
      period    <= '0;
      period_ok <= 1'b0;
      seen      <= 1'b0;
    end else begin
      vs_l    <= vs;
      vs_fall <= fall;
      if (downloading) begin
        cnt       <= '0;
        period_ok <= 1'b0;
        seen      <= 1'b0;
      end else if (fall) begin
        // A saturated count is reported as all-ones, never trusted.
        cnt       <= '0;
        period    <= sat ? '1 : cnt + 1'b1;
        period_ok <= seen & ~sat;
        seen      <= 1'b1;
      end else begin
        if (!sat) cnt <= cnt + 1'b1;
        if (sat) period_ok <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/jtframe_frame_mon.sv
// Frame counter and dump-window FSM driven by vertical sync.
// Window opens at frame START and closes LEN frames later.
module jtframe_frame_mon
  import jtframe_frame_mon_pkg::*;
#(
  parameter logic [31:0] START = 32'd0,
  parameter logic [31:0] LEN   = 32'd0,
  parameter int          PW    = 24
) (
  input  logic           rst,
  input  logic           clk,
  input  logic           vs,
  input  logic           downloading,
  output logic           vs_fall,
  output logic [FCW-1:0] frame_cnt,
  output logic           dump_en,
  output logic           dump_start,
  output logic           dump_stop,
  output logic [PW-1:0]  period,
  output logic           period_ok
);

  localparam logic [FCW-1:0] STOP_AT = START + LEN;

  fsm_t           state;
  logic           fall;
  logic [FCW-1:0] nxt_cnt;

  assign nxt_cnt = frame_cnt + 1'b1;

  jtframe_vs_period #(
    .PW (PW)
  ) u_period (
    .clk         (clk),
    .rst         (rst),
    .vs          (vs),
    .downloading (downloading),
    .fall        (fall),
    .vs_fall     (vs_fall),
    .period      (period),
    .period_ok   (period_ok)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WAIT_DL;
      frame_cnt  <= '0;
      dump_en    <= 1'b0;
      dump_start <= 1'b0;
      dump_stop  <= 1'b0;
    end else begin
      dump_start <= 1'b0;
      dump_stop  <= 1'b0;
      if (downloading) begin
        frame_cnt <= '0;
        state     <= WAIT_DL;
        dump_en   <= 1'b0;
        dump_stop <= (state == DUMPING);
      end else begin
        if (fall) frame_cnt <= nxt_cnt;
        unique case (state)
          WAIT_DL: begin
            // START = 0 opens without waiting for a frame
            if (START == '0) begin
              state      <= DUMPING;
              dump_en    <= 1'b1;
              dump_start <= 1'b1;
            end else begin
              state <= ARMED;
            end
          end
          ARMED: begin
            if (fall && nxt_cnt == START) begin
              state      <= DUMPING;
              dump_en    <= 1'b1;
              dump_start <= 1'b1;
            end
          end
          DUMPING: begin
            if (fall && LEN != '0 && nxt_cnt == STOP_AT) begin
              state     <= DONE;
              dump_en   <= 1'b0;
              dump_stop <= 1'b1;
            end
          end
          DONE: begin
            state <= DONE;
          end
          default: state <= WAIT_DL;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jtframe_frame_mon.sv
// Scoreboard bench for jtframe_frame_mon.
// Instance A: START=3 LEN=2; instance B: START=0 LEN=0.
module tb_jtframe_frame_mon;
  import jtframe_frame_mon_pkg::*;

  logic clk = 1'b0;
  logic rst_a = 1'b1, rst_b = 1'b1;
  logic vs_a = 1'b1, vs_b = 1'b1;
  logic dl_a = 1'b0, dl_b = 1'b1;

  logic           a_vf, a_en, a_st, a_sp, a_ok;
  logic [FCW-1:0] a_cnt;
  logic [9:0]     a_per;
  logic           b_vf, b_en, b_st, b_sp, b_ok;
  logic [FCW-1:0] b_cnt;
  logic [9:0]     b_per;

  int pass_n = 0;
  int tot_n  = 0;
  int b_stops = 0;
  int b_en_low = 0;
  logic b_watch = 1'b0;

  typedef struct {
    logic        vf;
    logic [31:0] cnt;
    logic        st;
    logic        sp;
    logic        en;
    logic        cp;
    logic [9:0]  per;
    logic        ok;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  jtframe_frame_mon #(.START(32'd3), .LEN(32'd2), .PW(10)) u_a (
    .rst (rst_a), .clk (clk), .vs (vs_a), .downloading (dl_a),
    .vs_fall (a_vf), .frame_cnt (a_cnt), .dump_en (a_en),
    .dump_start (a_st), .dump_stop (a_sp),
    .period (a_per), .period_ok (a_ok)
  );

  jtframe_frame_mon #(.START(32'd0), .LEN(32'd0), .PW(10)) u_b (
    .rst (rst_b), .clk (clk), .vs (vs_b), .downloading (dl_b),
    .vs_fall (b_vf), .frame_cnt (b_cnt), .dump_en (b_en),
    .dump_start (b_st), .dump_stop (b_sp),
    .period (b_per), .period_ok (b_ok)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: run did not complete");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic ev(input logic vf, input logic [31:0] cnt,
                    input logic st, input logic sp, input logic en,
                    input logic cp, input logic [9:0] per,
                    input logic ok);
    exp_t e;
    e.vf = vf; e.cnt = cnt; e.st = st; e.sp = sp;
    e.en = en; e.cp = cp; e.per = per; e.ok = ok;
    q.push_back(e);
  endtask

  // Monitor: any event on A pops one expected entry.
  always @(posedge clk) begin
    #1;
    if (!rst_a && (a_vf || a_st || a_sp)) begin
      if (q.size() == 0) begin
        chk("unexpected_event", 32'd1, 32'd0);
      end else begin
        mon_e = q.pop_front();
        chk("vs_fall", a_vf, mon_e.vf);
        chk("frame_cnt", a_cnt, mon_e.cnt);
        chk("dump_start", a_st, mon_e.st);
        chk("dump_stop", a_sp, mon_e.sp);
        chk("dump_en", a_en, mon_e.en);
        chk("period_ok", a_ok, mon_e.ok);
        if (mon_e.cp) chk("period", a_per, mon_e.per);
      end
    end
    if (b_watch && !rst_b) begin
      if (b_sp) b_stops++;
      if (!b_en) b_en_low++;
    end
  end

  task automatic frame_a(input int lo, input int dl_at, input bit chk_dl);
    vs_a = 1'b1;
    repeat (10) @(negedge clk);
    vs_a = 1'b0;
    for (int i = 0; i < lo; i++) begin
      if (i == dl_at) dl_a = 1'b1;
      @(negedge clk);
      if (chk_dl && i == 1) begin
        chk("dl_frame_cnt", a_cnt, 32'd0);
        chk("dl_period_ok", a_ok, 32'd0);
      end
    end
  endtask

  task automatic frame_b();
    vs_b = 1'b1;
    repeat (5) @(negedge clk);
    vs_b = 1'b0;
    repeat (15) @(negedge clk);
  endtask

  initial begin
    // Instance B: immediate window, never closes, counter wrap
    repeat (3) @(negedge clk);
    rst_b = 1'b0;
    repeat (5) @(negedge clk);
    chk("b_dl_en", b_en, 32'd0);
    chk("b_dl_start", b_st, 32'd0);
    dl_b = 1'b0;
    @(posedge clk); #1;
    chk("b_start_pulse", b_st, 32'd1);
    chk("b_en_open", b_en, 32'd1);
    @(posedge clk); #1;
    chk("b_start_once", b_st, 32'd0);
    b_watch = 1'b1;
    @(negedge clk);
    for (int f = 0; f < 100; f++) frame_b();
    b_watch = 1'b0;
    chk("b_no_stop", b_stops, 32'd0);
    chk("b_en_stayed", b_en_low, 32'd0);
    chk("b_frames", b_cnt, 32'd100);
    force u_b.frame_cnt = 32'hFFFF_FFFE;
    @(negedge clk);
    release u_b.frame_cnt;
    @(negedge clk);
    chk("b_preload", b_cnt, 32'hFFFF_FFFE);
    vs_b = 1'b1;
    repeat (5) @(negedge clk);
    vs_b = 1'b0;
    @(negedge clk);
    chk("b_wrap_vf", b_vf, 32'd1);
    chk("b_wrap_ff", b_cnt, 32'hFFFF_FFFF);
    repeat (14) @(negedge clk);
    frame_b();
    chk("b_wrap_0", b_cnt, 32'd0);
    chk("b_wrap_en", b_en, 32'd1);
    rst_b = 1'b1;
    @(posedge clk); #1;
    chk("b_rst_en", b_en, 32'd0);
    chk("b_rst_stop", b_sp, 32'd0);

    // Instance A: reset state
    @(negedge clk);
    chk("a_rst_vf", a_vf, 32'd0);
    chk("a_rst_cnt", a_cnt, 32'd0);
    chk("a_rst_en", a_en, 32'd0);
    chk("a_rst_start", a_st, 32'd0);
    chk("a_rst_stop", a_sp, 32'd0);
    chk("a_rst_period", a_per, 32'd0);
    chk("a_rst_ok", a_ok, 32'd0);
    rst_a = 1'b0;
    @(negedge clk);

    // Normal window: opens at frame 3, closes at frame 5
    ev(1, 1, 0, 0, 0, 0, 10'd0, 0);    frame_a(990, -1, 0);
    ev(1, 2, 0, 0, 0, 1, 10'd1000, 1); frame_a(990, -1, 0);
    ev(1, 3, 1, 0, 1, 1, 10'd1000, 1); frame_a(990, -1, 0);
    ev(1, 4, 0, 0, 1, 1, 10'd1000, 1); frame_a(990, -1, 0);
    ev(1, 5, 0, 1, 0, 1, 10'd1000, 1); frame_a(990, -1, 0);
    ev(1, 6, 0, 0, 0, 1, 10'd1000, 1); frame_a(990, -1, 0);

    // Download for 5 frames: no events, count held at 0
    dl_a = 1'b1;
    for (int f = 0; f < 5; f++) frame_a(990, -1, 1);
    dl_a = 1'b0;
    ev(1, 1, 0, 0, 0, 0, 10'd0, 0);    frame_a(990, -1, 0);
    ev(1, 2, 0, 0, 0, 1, 10'd1000, 1); frame_a(990, -1, 0);
    ev(1, 3, 1, 0, 1, 1, 10'd1000, 1); frame_a(990, -1, 0);

    // Download while the window is open aborts it
    ev(1, 4, 0, 0, 1, 1, 10'd1000, 1);
    ev(0, 0, 0, 1, 0, 0, 10'd0, 0);
    frame_a(990, 500, 0);
    frame_a(990, -1, 1);
    dl_a = 1'b0;
    ev(1, 1, 0, 0, 0, 0, 10'd0, 0);    frame_a(990, -1, 0);
    ev(1, 2, 0, 0, 0, 1, 10'd1000, 1); frame_a(990, -1, 0);
    ev(1, 3, 1, 0, 1, 1, 10'd1000, 1); frame_a(990, -1, 0);
    ev(1, 4, 0, 0, 1, 1, 10'd1000, 1); frame_a(990, -1, 0);
    ev(1, 5, 0, 1, 0, 1, 10'd1000, 1); frame_a(990, -1, 0);

    // Period saturation: long low phase after frame 6
    ev(1, 6, 0, 0, 0, 1, 10'd1000, 1); frame_a(1100, -1, 0);
    chk("sat_ok_drop", a_ok, 32'd0);
    ev(1, 7, 0, 0, 0, 1, 10'h3FF, 0);  frame_a(990, -1, 0);
    ev(1, 8, 0, 0, 0, 1, 10'd1000, 1); frame_a(990, -1, 0);

    repeat (5) @(negedge clk);
    chk("queue_empty", q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

endmodule

// File: doc/jtframe_frame_mon.md
Name: jtframe_frame_mon

Overview:
- Producer side of the simulation dump-trigger interface: derives the frame count and dump window from the video vertical sync.
- Output consumers: the dump controller in the test harness and any on-chip logic that needs a frame index.
- Detects vertical sync falling edges, counts frames while no ROM download is active, and measures the frame period in clocks.
- Runs an FSM that opens a dump window at a programmed frame and closes it after a programmed length.
- Synthesizable; it is also instantiated in simulation top levels.

Parameters:
- START, 32'd0: frame number at which the dump window opens.
- LEN, 32'd0: window length in frames; 0 = never closes.
- PW, 24: width of the frame-period counter.

Ports:
- rst  input  1  synchronous reset, active-high
- clk  input  1  system clock
- vs  input  1  vertical sync, already synchronous to clk, active-high
- downloading  input  1  ROM download in progress (LED signal)
- vs_fall  output  1  one-cycle pulse per vs falling edge
- frame_cnt  output  32  frames counted since download finished
- dump_en  output  1  high while the dump window is open
- dump_start  output  1  one-cycle pulse when the window opens
- dump_stop  output  1  one-cycle pulse when the window closes
- period  output  PW  clocks between the last two vs falling edges
- period_ok  output  1  period holds a valid measurement

Behaviour:
- Reset: all outputs 0. FSM = WAIT_DL. vs_l = 1, so no false edge is seen out of reset. Cycle counter = 0.
- Edge detect:
  - vs_l registers vs.
  - fall = vs_l & ~vs.
  - vs_fall is registered, so it is high in the cycle after vs is first sampled low (latency 1).
- frame_cnt:
  - Held at 0 while downloading = 1.
  - Otherwise increments by 1 in the same cycle vs_fall rises.
  - Wraps 32'hFFFFFFFF -> 0 with no flag.
- Period:
  - A cycle counter increments every clk and saturates at all-ones.
  - On each fall, period <= counter + 1 (cycles since the previous fall, inclusive) and the counter clears to 0.
  - period_ok sets on the second fall after reset or after download ends. It clears whenever downloading = 1 or the counter saturates.
  - The counter is held at 0 while downloading = 1.
- FSM states:
  - WAIT_DL:
    - Goes to ARMED in the first cycle with downloading = 0.
    - Exception: if START = 0 and LEN = 0, it goes directly to DUMPING with a dump_start pulse, with no frame wait.
  - ARMED:
    - Goes to DUMPING on fall when the post-increment frame count equals START.
    - In that transition: dump_en = 1 and dump_start pulses, both in the same cycle as vs_fall.
  - DUMPING:
    - Goes to DONE on fall when LEN != 0 and the post-increment count equals START + LEN (32-bit wrap sum).
    - In that transition: dump_en = 0 and dump_stop pulses.
    - LEN = 0 keeps the window open forever.
  - DONE: terminal; only reset or a new download leaves it.
- downloading rising in any state:
  - FSM goes to WAIT_DL next cycle and dump_en drops.
  - If the FSM was in DUMPING, dump_stop pulses.
  - No pulses are generated while downloading.
- Simultaneous events:
  - A fall in the same cycle downloading rises is ignored; download wins.
  - START = 0 with LEN != 0 opens the window on leaving WAIT_DL, without waiting for a frame.
- Reset mid-window: dump_en drops next cycle with no dump_stop pulse.

Decomposition:
- Shared package holds:
  - FSM state enum: WAIT_DL, ARMED, DUMPING, DONE (2 bits).
  - Frame-count width constant FCW = 32, shared with harness consumers.
- One natural sub-module: jtframe_vs_period (edge detect, cycle counter, period capture). The FSM and frame counter stay in the top module.

Test Plan:
- Reset, downloading = 0, vs period 1000 clk with high time 10 clk, START = 3, LEN = 2:
  - frame_cnt reaches 1, 2, 3.
  - dump_start pulses with vs_fall of frame 3.
  - dump_en stays high through frame 4.
  - dump_stop pulses with vs_fall of frame 5.
  - period = 1000 from the second fall.
  - period_ok = 1 from the second fall.
- downloading = 1 for 5 frames, then 0:
  - frame_cnt stays 0 and period_ok stays 0 during download.
  - Counting restarts at 1 on the first fall after the download.
- downloading asserted while dump_en = 1:
  - dump_stop pulses once and dump_en = 0 next cycle.
  - After downloading clears, the window reopens at frame START.
- START = 0, LEN = 0: dump_start pulses one cycle after downloading clears; the window never closes over 100 frames.
- Force frame_cnt to 32'hFFFFFFFE via the reset-free preload hook or by running 2^32 frames in a fast model: the next falls give FFFFFFFF, then 0.
- vs held low for 2^PW clocks: period_ok drops on saturation; the next fall captures a saturated period with period_ok = 0; the following fall restores period_ok = 1.
